// File: rtl/ctrl_pipe_unit.sv
// ============================================================================
// Module      : ctrl_pipe_unit
// Description : Pipelined main control for the 5-stage RV32I core. Decodes the
//               opcode in ID, carries the 12-bit control bundle and rd through
//               ID/EX, EX/MEM and MEM/WB, inserts bubbles on flush and on
//               load-use hazards, and counts inserted bubbles (saturating).
//               Optional feature macro: CTRL_HAZARD_EN (load-use detection).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_pipe_unit #(
  parameter int OPC_W   = 7,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [OPC_W-1:0]   id_opcode,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               flush,
  output logic               hazard_stall,
  output logic [11:0]        ex_ctrl,
  output logic [RADDR_W-1:0] ex_rd,
  output logic [11:0]        mem_ctrl,
  output logic [RADDR_W-1:0] mem_rd,
  output logic [11:0]        wb_ctrl,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]   bubble_cnt
);

  // Opcodes (inst[6:0])
  localparam logic [OPC_W-1:0] C_OPC_R      = OPC_W'(7'b0110011);
  localparam logic [OPC_W-1:0] C_OPC_LOAD   = OPC_W'(7'b0000011);
  localparam logic [OPC_W-1:0] C_OPC_STORE  = OPC_W'(7'b0100011);
  localparam logic [OPC_W-1:0] C_OPC_BRANCH = OPC_W'(7'b1100011);
  localparam logic [OPC_W-1:0] C_OPC_IALU   = OPC_W'(7'b0010011);
  localparam logic [OPC_W-1:0] C_OPC_LUI    = OPC_W'(7'b0110111);
  localparam logic [OPC_W-1:0] C_OPC_AUIPC  = OPC_W'(7'b0010111);
  localparam logic [OPC_W-1:0] C_OPC_JAL    = OPC_W'(7'b1101111);
  localparam logic [OPC_W-1:0] C_OPC_JALR   = OPC_W'(7'b1100111);

  // Bundle: [0]branch [1]jump [2]mem_read [3]mem_to_reg [4]mem_write
  //         [5]alu_src [6]reg_write [7]lui [8]auipc [10:9]alu_op [11]illegal
  localparam logic [11:0] C_BND_R       = 12'h440; // reg_write, alu_op=10
  localparam logic [11:0] C_BND_LOAD    = 12'h06C; // mem_read, mem_to_reg, alu_src, reg_write
  localparam logic [11:0] C_BND_STORE   = 12'h030; // mem_write, alu_src
  localparam logic [11:0] C_BND_BRANCH  = 12'h201; // branch, alu_op=01
  localparam logic [11:0] C_BND_IALU    = 12'h660; // alu_src, reg_write, alu_op=11
  localparam logic [11:0] C_BND_LUI     = 12'h6E0; // alu_src, reg_write, lui, alu_op=11
  localparam logic [11:0] C_BND_AUIPC   = 12'h160; // alu_src, reg_write, auipc
  localparam logic [11:0] C_BND_JUMP    = 12'h062; // jump, alu_src, reg_write
  localparam logic [11:0] C_BND_ILLEGAL = 12'h800;
  localparam logic [11:0] C_BND_BUBBLE  = 12'h000;

  logic [11:0]        w_dec;
  logic               w_hazard;
  logic               w_bubble_evt;

  logic [11:0]        r_ex_ctrl;
  logic [RADDR_W-1:0] r_ex_rd;
  logic [11:0]        r_mem_ctrl;
  logic [RADDR_W-1:0] r_mem_rd;
  logic [11:0]        r_wb_ctrl;
  logic [RADDR_W-1:0] r_wb_rd;
  logic [CNT_W-1:0]   r_cnt;

  // Opcode decode of the instruction currently in ID
  always_comb begin
    w_dec = C_BND_ILLEGAL;
    case (id_opcode)
      C_OPC_R:      w_dec = C_BND_R;
      C_OPC_LOAD:   w_dec = C_BND_LOAD;
      C_OPC_STORE:  w_dec = C_BND_STORE;
      C_OPC_BRANCH: w_dec = C_BND_BRANCH;
      C_OPC_IALU:   w_dec = C_BND_IALU;
      C_OPC_LUI:    w_dec = C_BND_LUI;
      C_OPC_AUIPC:  w_dec = C_BND_AUIPC;
      C_OPC_JAL:    w_dec = C_BND_JUMP;
      C_OPC_JALR:   w_dec = C_BND_JUMP;
      default:      w_dec = C_BND_ILLEGAL;
    endcase
  end

`ifdef CTRL_HAZARD_EN
  logic w_uses_rs1;
  logic w_uses_rs2;

  // Source-register usage; rd==x0 in EX never creates a dependency
  always_comb begin
    w_uses_rs1 = !((id_opcode == C_OPC_LUI) || (id_opcode == C_OPC_AUIPC) ||
                   (id_opcode == C_OPC_JAL));
    w_uses_rs2 = (id_opcode == C_OPC_R) || (id_opcode == C_OPC_STORE) ||
                 (id_opcode == C_OPC_BRANCH);
    w_hazard   = id_valid && r_ex_ctrl[2] && (r_ex_rd != '0) &&
                 ((w_uses_rs1 && (r_ex_rd == id_rs1)) ||
                  (w_uses_rs2 && (r_ex_rd == id_rs2)));
  end
`else
  // Without detection software schedules around loads; source fields are unused
  logic w_unused_rs;
  assign w_unused_rs = ^{id_rs1, id_rs2};
  assign w_hazard    = 1'b0;
`endif

  assign w_bubble_evt = flush || w_hazard;

  // ID/EX register: flush, then stall, then invalid ID all insert a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_ctrl <= C_BND_BUBBLE;
      r_ex_rd   <= '0;
    end else if (flush || w_hazard || !id_valid) begin
      r_ex_ctrl <= C_BND_BUBBLE;
      r_ex_rd   <= '0;
    end else begin
      r_ex_ctrl <= w_dec;
      r_ex_rd   <= id_rd;
    end
  end

  // EX/MEM and MEM/WB advance every cycle; the flushing instruction proceeds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_ctrl <= C_BND_BUBBLE;
      r_mem_rd   <= '0;
      r_wb_ctrl  <= C_BND_BUBBLE;
      r_wb_rd    <= '0;
    end else begin
      r_mem_ctrl <= r_ex_ctrl;
      r_mem_rd   <= r_ex_rd;
      r_wb_ctrl  <= r_mem_ctrl;
      r_wb_rd    <= r_mem_rd;
    end
  end

  // Saturating bubble counter; simultaneous flush and stall is one bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_bubble_evt && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign hazard_stall = w_hazard;
  assign ex_ctrl      = r_ex_ctrl;
  assign ex_rd        = r_ex_rd;
  assign mem_ctrl     = r_mem_ctrl;
  assign mem_rd       = r_mem_rd;
  assign wb_ctrl      = r_wb_ctrl;
  assign wb_rd        = r_wb_rd;
  assign bubble_cnt   = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe_unit.sv
// ============================================================================
// Module      : tb_ctrl_pipe_unit
// Description : Scoreboard bench for ctrl_pipe_unit. The driver issues directed
//               vectors with hand-computed ID/EX results and pushes expected
//               pipeline state; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_pipe_unit;

`ifdef CTRL_HAZARD_EN
  localparam logic C_HZ = 1'b1;
`else
  localparam logic C_HZ = 1'b0;
`endif

  localparam logic [6:0] C_R      = 7'b0110011;
  localparam logic [6:0] C_LOAD   = 7'b0000011;
  localparam logic [6:0] C_STORE  = 7'b0100011;
  localparam logic [6:0] C_BRANCH = 7'b1100011;
  localparam logic [6:0] C_IALU   = 7'b0010011;
  localparam logic [6:0] C_LUI    = 7'b0110111;
  localparam logic [6:0] C_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_JAL    = 7'b1101111;
  localparam logic [6:0] C_JALR   = 7'b1100111;
  localparam logic [6:0] C_ILL    = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [6:0]  id_opcode = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        flush = 1'b0;

  logic        hazard_stall;
  logic [11:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic [15:0] bubble_cnt;

  logic        s_stall;
  logic [11:0] s_ex_ctrl, s_mem_ctrl, s_wb_ctrl;
  logic [4:0]  s_ex_rd, s_mem_rd, s_wb_rd;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  ctrl_pipe_unit #(.OPC_W(7), .RADDR_W(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
    .hazard_stall(hazard_stall), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
    .mem_ctrl(mem_ctrl), .mem_rd(mem_rd), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd),
    .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation
  ctrl_pipe_unit #(.OPC_W(7), .RADDR_W(5), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
    .hazard_stall(s_stall), .ex_ctrl(s_ex_ctrl), .ex_rd(s_ex_rd),
    .mem_ctrl(s_mem_ctrl), .mem_rd(s_mem_rd), .wb_ctrl(s_wb_ctrl), .wb_rd(s_wb_rd),
    .bubble_cnt(s_cnt)
  );

  typedef struct {
    logic        stall;
    logic [11:0] ex, mem, wb;
    logic [4:0]  exrd, memrd, wbrd;
    logic [15:0] cnt;
    logic [1:0]  scnt;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   have_pend = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // Reference pipeline state following the hand-computed ID/EX results
  logic [11:0] m_ex = '0, m_mem = '0, m_wb = '0;
  logic [4:0]  m_exrd = '0, m_memrd = '0, m_wbrd = '0;
  logic [15:0] m_cnt = '0;
  logic [1:0]  m_scnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_exrd = '0; m_memrd = '0; m_wbrd = '0;
    m_cnt = '0; m_scnt = '0;
  endtask

  // Apply one ID-stage vector for one cycle; exp_st/exp_ex/exp_rd are hand-computed
  task automatic step(input logic v, input logic [6:0] opc, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic fl,
                      input logic exp_st, input logic [11:0] exp_ex, input logic [4:0] exp_rd);
    exp_t e;
    @(posedge clk); #1;
    id_valid = v; id_opcode = opc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; flush = fl;
    m_wb = m_mem;   m_wbrd = m_memrd;
    m_mem = m_ex;   m_memrd = m_exrd;
    m_ex = exp_ex;  m_exrd = exp_rd;
    if (fl || exp_st) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_scnt != 2'd3) m_scnt = m_scnt + 2'd1;
    end
    e.stall = exp_st;
    e.ex = m_ex;   e.exrd = m_exrd;
    e.mem = m_mem; e.memrd = m_memrd;
    e.wb = m_wb;   e.wbrd = m_wbrd;
    e.cnt = m_cnt; e.scnt = m_scnt;
    q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 12'h000, 5'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ex_ctrl"}, 32'(ex_ctrl), 0);
    chk({tag, " ex_rd"}, 32'(ex_rd), 0);
    chk({tag, " mem_ctrl"}, 32'(mem_ctrl), 0);
    chk({tag, " mem_rd"}, 32'(mem_rd), 0);
    chk({tag, " wb_ctrl"}, 32'(wb_ctrl), 0);
    chk({tag, " wb_rd"}, 32'(wb_rd), 0);
    chk({tag, " bubble_cnt"}, 32'(bubble_cnt), 0);
    chk({tag, " sat bubble_cnt"}, 32'(s_cnt), 0);
  endtask

  // Monitor: registered state from the previous edge, then this cycle's stall
  always @(negedge clk) begin
    if (have_pend) begin
      chk("ex_ctrl", 32'(ex_ctrl), 32'(pend.ex));
      chk("ex_rd", 32'(ex_rd), 32'(pend.exrd));
      chk("mem_ctrl", 32'(mem_ctrl), 32'(pend.mem));
      chk("mem_rd", 32'(mem_rd), 32'(pend.memrd));
      chk("wb_ctrl", 32'(wb_ctrl), 32'(pend.wb));
      chk("wb_rd", 32'(wb_rd), 32'(pend.wbrd));
      chk("bubble_cnt", 32'(bubble_cnt), 32'(pend.cnt));
      chk("sat bubble_cnt", 32'(s_cnt), 32'(pend.scnt));
      have_pend = 0;
    end
    if (q.size() != 0) begin
      pend = q.pop_front();
      chk("hazard_stall", 32'(hazard_stall), 32'(pend.stall));
      have_pend = 1;
    end
  end

  initial begin
    // Power-up reset
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Pipeline advance: R-type rd=5 walks EX, MEM, WB
    step(1, C_R, 5'd1, 5'd2, 5'd5, 0, 0, 12'h440, 5'd5);
    idle(); idle(); idle();

    // Load-use on rs1
    step(1, C_LOAD, 5'd1, 5'd0, 5'd3, 0, 0, 12'h06C, 5'd3);
`ifdef CTRL_HAZARD_EN
    step(1, C_R, 5'd3, 5'd4, 5'd6, 0, 1, 12'h000, 5'd0);
    step(1, C_R, 5'd3, 5'd4, 5'd6, 0, 0, 12'h440, 5'd6);
`else
    step(1, C_R, 5'd3, 5'd4, 5'd6, 0, 0, 12'h440, 5'd6);
`endif

    // Exclusions: load to x0, and LUI which reads no source
    step(1, C_LOAD, 5'd1, 5'd0, 5'd0, 0, 0, 12'h06C, 5'd0);
    step(1, C_R, 5'd0, 5'd0, 5'd7, 0, 0, 12'h440, 5'd7);
    step(1, C_LOAD, 5'd1, 5'd0, 5'd3, 0, 0, 12'h06C, 5'd3);
    step(1, C_LUI, 5'd3, 5'd3, 5'd3, 0, 0, 12'h6E0, 5'd3);

    // Load-use on rs2 of a store
    step(1, C_LOAD, 5'd1, 5'd0, 5'd4, 0, 0, 12'h06C, 5'd4);
`ifdef CTRL_HAZARD_EN
    step(1, C_STORE, 5'd1, 5'd4, 5'd0, 0, 1, 12'h000, 5'd0);
    step(1, C_STORE, 5'd1, 5'd4, 5'd0, 0, 0, 12'h030, 5'd0);
`else
    step(1, C_STORE, 5'd1, 5'd4, 5'd0, 0, 0, 12'h030, 5'd0);
`endif

    // Invalid ID never stalls; JAL reads no rs1
    step(1, C_LOAD, 5'd1, 5'd0, 5'd3, 0, 0, 12'h06C, 5'd3);
    step(0, C_R, 5'd3, 5'd3, 5'd6, 0, 0, 12'h000, 5'd0);
    step(1, C_LOAD, 5'd1, 5'd0, 5'd3, 0, 0, 12'h06C, 5'd3);
    step(1, C_JAL, 5'd3, 5'd3, 5'd1, 0, 0, 12'h062, 5'd1);

    // Flush kills the store in ID; the I-ALU ahead still reaches MEM
    step(1, C_IALU, 5'd2, 5'd0, 5'd8, 0, 0, 12'h660, 5'd8);
    step(1, C_STORE, 5'd1, 5'd2, 5'd0, 1, 0, 12'h000, 5'd0);

    // Flush and hazard together count as a single bubble
    step(1, C_LOAD, 5'd1, 5'd0, 5'd3, 0, 0, 12'h06C, 5'd3);
    step(1, C_R, 5'd3, 5'd2, 5'd6, 1, C_HZ, 12'h000, 5'd0);
    step(1, C_R, 5'd3, 5'd2, 5'd6, 0, 0, 12'h440, 5'd6);

    // Remaining decodes
    step(1, C_BRANCH, 5'd1, 5'd2, 5'd0, 0, 0, 12'h201, 5'd0);
    step(1, C_AUIPC, 5'd0, 5'd0, 5'd9, 0, 0, 12'h160, 5'd9);
    step(1, C_JALR, 5'd1, 5'd0, 5'd1, 0, 0, 12'h062, 5'd1);
    step(1, C_ILL, 5'd0, 5'd0, 5'd2, 0, 0, 12'h800, 5'd2);
    step(1, C_R, 5'd1, 5'd2, 5'd5, 0, 0, 12'h440, 5'd5);

    // Reset mid-stream, away from any clock edge
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b0;
    id_valid = 1'b0; flush = 1'b0;
    #1;
    chk_all_zero("mid reset");
    model_reset();
    #1;
    rst_n = 1'b1;

    // Recovery after reset
    step(1, C_R, 5'd1, 5'd2, 5'd10, 0, 0, 12'h440, 5'd10);
    idle(); idle();

    // Five consecutive flushes saturate the 2-bit counter at 3
    for (int i = 0; i < 5; i++)
      step(1, C_R, 5'd1, 5'd2, 5'd5, 1, 0, 12'h000, 5'd0);
    idle();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && (q.size() != 0 || have_pend); i++)
      @(negedge clk);
    #1;
    if (q.size() != 0 || have_pend) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
